// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl: dual-issue instruction fetch sequencer.
//
// Owns the fetch PC and issues paired reads (addr, addr+4) to a one-cycle
// instruction memory.  Returned pairs are stored with their PCs in a small
// circular queue, and decode is shown the queue head and the entry after it.
// A redirect flushes the queue, retargets the fetch PC and discards every
// response still in flight when the redirect is taken.
//
// Ports
//   fc_clk            clock
//   fc_rst            synchronous reset, active low
//   fc_o_im_ce        memory request strobe (one cycle per pair)
//   fc_o_im_addr_1/2  pair addresses, addr_2 = addr_1 + 4
//   fc_i_im_instr_1/2 returned instruction pair
//   fc_i_im_ce        response valid, one cycle after the request
//   fc_i_redirect     redirect request from branch resolution
//   fc_i_redirect_pc  redirect target (bits [1:0] ignored)
//   fc_o_instr_1/2    queue head / head+1 instruction
//   fc_o_pc_1/2       PCs of those instructions
//   fc_o_valid_1/2    queue holds at least 1 / 2 entries
//   fc_i_dec_take     entries consumed by decode this cycle (0..2, 3 acts as 2)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int                     PC_WIDTH = 32,
   parameter int                     IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0]    RESET_PC = '0,
   parameter int                     QDEPTH   = 4
) (
   input  logic                fc_clk,
   input  logic                fc_rst,
   output logic                fc_o_im_ce,
   output logic [PC_WIDTH-1:0] fc_o_im_addr_1,
   output logic [PC_WIDTH-1:0] fc_o_im_addr_2,
   input  logic [IWIDTH-1:0]   fc_i_im_instr_1,
   input  logic [IWIDTH-1:0]   fc_i_im_instr_2,
   input  logic                fc_i_im_ce,
   input  logic                fc_i_redirect,
   input  logic [PC_WIDTH-1:0] fc_i_redirect_pc,
   output logic [IWIDTH-1:0]   fc_o_instr_1,
   output logic [IWIDTH-1:0]   fc_o_instr_2,
   output logic [PC_WIDTH-1:0] fc_o_pc_1,
   output logic [PC_WIDTH-1:0] fc_o_pc_2,
   output logic                fc_o_valid_1,
   output logic                fc_o_valid_2,
   input  logic [1:0]          fc_i_dec_take
);

   localparam int PW = $clog2(QDEPTH);     // queue pointer width
   localparam int CW = $clog2(QDEPTH + 1); // occupancy width (0..QDEPTH)
   localparam int UW = CW + 2;             // credit arithmetic width

   typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [PC_WIDTH-1:0] fetch_pc;
   logic [CW-1:0]       count;
   logic [1:0]          pending;    // live requests awaiting a response
   logic [2:0]          drop;       // stale responses still to be discarded
   logic [PW-1:0]       head, tail;

   logic [IWIDTH-1:0]   q_instr [QDEPTH];
   logic [PC_WIDTH-1:0] q_pc    [QDEPTH];

   logic                req;
   logic                credit_ok;
   logic [UW-1:0]       used;
   logic                resp_live, resp_drop;
   logic [PC_WIDTH-1:0] resp_pc;
   logic [2:0]          stale, drop_redir;
   logic [1:0]          take_eff, deq;

   // pair slots, lane 0 = first instruction of the pair
   logic [1:0][IWIDTH-1:0]   rsp_instr;
   logic [1:0][PC_WIDTH-1:0] rsp_pcs;
   logic [1:0][PW-1:0]       wr_idx, rd_idx;
   logic [1:0]               lane_vld;
   logic [1:0][IWIDTH-1:0]   out_instr;
   logic [1:0][PC_WIDTH-1:0] out_pc;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge fc_clk) begin
      if (!fc_rst) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // IDLE lasts exactly one cycle; a redirect lands in FETCH as well,
   // so the FSM does not need to look at it.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req = 1'b0;
      if (fc_rst && state == S_FETCH && !fc_i_redirect &&
          pending < 2'd2 && credit_ok)
         req = 1'b1;
   end

   assign fc_o_im_ce     = req;
   assign fc_o_im_addr_1 = fetch_pc;
   assign fc_o_im_addr_2 = fetch_pc + PC_WIDTH'(4);

   // ---------------------------------------------------------------- credit
   // Registered occupancy plus two slots per live request; same-cycle
   // dequeues are deliberately not credited.
   assign used      = UW'(count) + UW'({pending, 1'b0});
   assign credit_ok = (used + UW'(2)) <= UW'(QDEPTH);

   // ---------------------------------------------------------------- response
   // Memory answers in order, so stale responses always come first.
   assign resp_drop = fc_i_im_ce && (drop != 3'd0);
   assign resp_live = fc_i_im_ce && (drop == 3'd0) && (pending != 2'd0);

   // fetch_pc has advanced 8 bytes per live request, so the oldest live
   // request started 8*pending bytes back.
   assign resp_pc = fetch_pc - PC_WIDTH'({pending, 3'b000});

   // On redirect every outstanding response becomes stale; one arriving
   // in the redirect cycle itself is already consumed here.
   assign stale      = drop + {1'b0, pending};
   assign drop_redir = stale - {2'b00, (fc_i_im_ce && stale != 3'd0)};

   // ---------------------------------------------------------------- dequeue
   always_comb begin
      take_eff = fc_i_dec_take[1] ? 2'd2 : {1'b0, fc_i_dec_take[0]};
      if (count >= CW'(take_eff)) deq = take_eff;
      else                        deq = count[1:0];
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge fc_clk) begin
      if (!fc_rst) begin
         fetch_pc <= RESET_PC;
         count    <= '0;
         pending  <= '0;
         drop     <= '0;
         head     <= '0;
         tail     <= '0;
      end else if (fc_i_redirect) begin
         fetch_pc <= {fc_i_redirect_pc[PC_WIDTH-1:2], 2'b00};
         count    <= '0;
         pending  <= '0;
         drop     <= drop_redir;
         head     <= '0;
         tail     <= '0;
      end else begin
         if (req) fetch_pc <= fetch_pc + PC_WIDTH'(8);
         pending <= pending + {1'b0, req} - {1'b0, resp_live};
         if (resp_drop) drop <= drop - 3'd1;
         if (resp_live) tail <= tail + PW'(2);
         head  <= head + PW'(deq);
         count <= count + (resp_live ? CW'(2) : CW'(0)) - CW'(deq);
      end
   end

   // ---------------------------------------------------------------- lanes
   assign rsp_instr = {fc_i_im_instr_2, fc_i_im_instr_1};

   for (genvar l = 0; l < 2; l++) begin : g_lane
      assign rsp_pcs[l]  = resp_pc + PC_WIDTH'(4 * l);
      assign wr_idx[l]   = tail + PW'(l);
      assign rd_idx[l]   = head + PW'(l);
      assign lane_vld[l] = count > CW'(l);
      // Outputs are forced to zero when their lane is empty so reset and
      // flush present a clean bus.
      assign out_instr[l] = lane_vld[l] ? q_instr[rd_idx[l]] : '0;
      assign out_pc[l]    = lane_vld[l] ? q_pc[rd_idx[l]]    : '0;
   end

   // Storage needs no reset: nothing is visible until count covers it.
   always_ff @(posedge fc_clk) begin
      if (fc_rst && !fc_i_redirect && resp_live) begin
         for (int l = 0; l < 2; l++) begin
            q_instr[wr_idx[l]] <= rsp_instr[l];
            q_pc[wr_idx[l]]    <= rsp_pcs[l];
         end
      end
   end

   assign fc_o_valid_1 = lane_vld[0];
   assign fc_o_valid_2 = lane_vld[1];
   assign fc_o_instr_1 = out_instr[0];
   assign fc_o_instr_2 = out_instr[1];
   assign fc_o_pc_1    = out_pc[0];
   assign fc_o_pc_2    = out_pc[1];

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl: randomized bench for fetch_ctrl with a queue-based reference
// model, a one-cycle memory responder and a few literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;
   localparam int QD = 4;

   logic        clk, rst;
   logic        ce, i_ce, redirect, v1, v2, inj;
   logic [31:0] a1, a2, m_i1, m_i2, rpc, o_i1, o_i2, o_p1, o_p2, key;
   logic [1:0]  take;

   fetch_ctrl #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0), .QDEPTH(QD)) dut (
      .fc_clk(clk), .fc_rst(rst),
      .fc_o_im_ce(ce), .fc_o_im_addr_1(a1), .fc_o_im_addr_2(a2),
      .fc_i_im_instr_1(m_i1), .fc_i_im_instr_2(m_i2), .fc_i_im_ce(i_ce),
      .fc_i_redirect(redirect), .fc_i_redirect_pc(rpc),
      .fc_o_instr_1(o_i1), .fc_o_instr_2(o_i2), .fc_o_pc_1(o_p1), .fc_o_pc_2(o_p2),
      .fc_o_valid_1(v1), .fc_o_valid_2(v2), .fc_i_dec_take(take));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- memory
   logic        rsp_ce;
   logic [31:0] rsp_a1, rsp_a2;
   initial begin
      rsp_ce = 0; rsp_a1 = 0; rsp_a2 = 0;
      forever begin
         @(posedge clk);
         rsp_ce <= ce;
         rsp_a1 <= a1;
         rsp_a2 <= a2;
      end
   end
   assign i_ce = rsp_ce | inj;
   assign m_i1 = rsp_a1 ^ key;
   assign m_i2 = rsp_a2 ^ key;

   // ---------------------------------------------------------------- model
   // queue of (instr, pc); in-flight list of (addr, stale)
   logic [31:0] mq_i[$], mq_p[$], infl_a[$];
   bit          infl_s[$];
   logic [31:0] m_pc;
   bit          m_idle, mdl_ok;

   function automatic logic exp_req();
      int live = 0;
      foreach (infl_s[i]) if (!infl_s[i]) live++;
      return rst && !m_idle && !redirect && live < 2 &&
             (mq_p.size() + 2 * live + 2 <= QD);
   endfunction

   initial begin
      mdl_ok = 0; m_idle = 1; m_pc = 0;
      forever begin
         @(posedge clk);
         if (!rst) begin
            mq_i.delete(); mq_p.delete(); infl_a.delete(); infl_s.delete();
            m_pc = 32'h0; m_idle = 1; mdl_ok = 1;
         end else begin
            logic r;
            int   old, n;
            logic [31:0] a;
            bit   s;
            r   = exp_req();
            old = mq_p.size();
            if (i_ce && infl_a.size() > 0) begin
               a = infl_a.pop_front();
               s = infl_s.pop_front();
               if (!s && !redirect) begin
                  mq_i.push_back(m_i1); mq_p.push_back(a);
                  mq_i.push_back(m_i2); mq_p.push_back(a + 32'd4);
               end
            end
            if (redirect) begin
               mq_i.delete(); mq_p.delete();
               foreach (infl_s[i]) infl_s[i] = 1;
               m_pc = {rpc[31:2], 2'b00};
            end else begin
               n = (take >= 2) ? 2 : int'(take);
               if (n > old) n = old;
               repeat (n) begin
                  void'(mq_i.pop_front());
                  void'(mq_p.pop_front());
               end
               if (r) begin
                  infl_a.push_back(m_pc); infl_s.push_back(0);
                  m_pc = m_pc + 32'd8;
               end
            end
            m_idle = 0;
         end
      end
   end

   // ---------------------------------------------------------------- compare
   initial begin
      forever begin
         @(negedge clk);
         if (mdl_ok) begin
            logic e;
            e = exp_req();
            chk("ce", 32'(ce), 32'(e));
            if (e) begin
               chk("addr_1", a1, m_pc);
               chk("addr_2", a2, m_pc + 32'd4);
            end
            chk("valid_1", 32'(v1), 32'(mq_p.size() >= 1));
            chk("valid_2", 32'(v2), 32'(mq_p.size() >= 2));
            if (mq_p.size() >= 1) begin
               chk("instr_1", o_i1, mq_i[0]);
               chk("pc_1", o_p1, mq_p[0]);
            end
            if (mq_p.size() >= 2) begin
               chk("instr_2", o_i2, mq_i[1]);
               chk("pc_2", o_p2, mq_p[1]);
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Stop in the cycle right after one that issued a request.
   task automatic after_req(input string nm);
      int n = 0;
      neg();
      while (!ce && n < 16) begin
         step(); neg(); n++;
      end
      chk(nm, 32'(ce), 32'd1);
      step();
   endtask

   initial begin
      rst = 0; redirect = 0; take = 0; rpc = 0; inj = 0; key = 0;
      step(); step();
      neg();
      chk("rst_valid_1", 32'(v1), 32'd0);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_instr_1", o_i1, 32'd0);
      chk("rst_pc_1", o_p1, 32'd0);
      step(); rst = 1;
      neg(); chk("idle_ce", 32'(ce), 32'd0);
      step();
      neg(); chk("first_ce", 32'(ce), 32'd1);
      chk("first_a1", a1, 32'h0); chk("first_a2", a2, 32'h4);
      step();
      neg(); chk("second_a1", a1, 32'h8); chk("second_a2", a2, 32'hC);
      repeat (4) step();
      neg();
      chk("full_ce", 32'(ce), 32'd0);
      chk("full_v2", 32'(v2), 32'd1);
      chk("full_i1", o_i1, 32'h0); chk("full_i2", o_i2, 32'h4);
      chk("full_p2", o_p2, 32'h4);

      // streaming drain
      step(); take = 2;
      repeat (12) step();

      // redirect with a response arriving in the redirect cycle
      after_req("wait_req_redir");
      redirect = 1; rpc = 32'h0000_0106;
      neg(); chk("redir_ce", 32'(ce), 32'd0);
      step(); redirect = 0; take = 0;
      neg();
      chk("redir_req", 32'(ce), 32'd1);
      chk("redir_a1", a1, 32'h104); chk("redir_a2", a2, 32'h108);
      chk("redir_empty", 32'(v1), 32'd0);
      step(); neg(); chk("redir_empty2", 32'(v1), 32'd0);
      step(); neg();
      chk("redir_v1", 32'(v1), 32'd1);
      chk("redir_pc1", o_p1, 32'h104);
      chk("redir_i1", o_i1, 32'h104);
      chk("redir_pc2", o_p2, 32'h108);

      // reset mid-stream, spurious response right after it
      step(); take = 2;
      repeat (6) step();
      after_req("wait_req_rst");
      rst = 0;
      neg(); chk("rst_mid_ce", 32'(ce), 32'd0);
      step(); rst = 1; inj = 1;
      neg(); chk("rst_mid_v1", 32'(v1), 32'd0); chk("rst_mid_idle", 32'(ce), 32'd0);
      step(); inj = 0;
      neg();
      chk("rst_mid_v1b", 32'(v1), 32'd0);
      chk("rst_restart", 32'(ce), 32'd1);
      chk("rst_restart_a1", a1, 32'h0);

      // random traffic
      step(); key = $urandom;
      repeat (3000) begin
         step();
         rst      = ($urandom_range(199) != 0);
         redirect = ($urandom_range(11) == 0);
         rpc      = $urandom;
         take     = 2'($urandom_range(3));
      end
      step(); rst = 1; redirect = 0; take = 0;
      repeat (4) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
